// File: rtl/wbs_uart_rx_if.sv
// Wishbone read-only slave bundle for wbs_uart_rx: strobe/address in, data/ack out.
interface wbs_uart_rx_if;
   logic       wb_stb_i;
   logic       wb_adr_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   modport slave  (input  wb_stb_i, wb_adr_i, output wb_dat_o, wb_ack_o);
   modport master (output wb_stb_i, wb_adr_i, input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wbs_uart_rx.sv
// 8N1 UART receiver with a one-deep holding register behind a Wishbone read-only slave.
// Optional 2-of-3 majority sampling: define WBS_UART_RX_MAJORITY_EN.
module wbs_uart_rx #(
   parameter int TICKS_PER_BAUD = 104
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   wbs_uart_rx_if.slave        wbs,
   input  logic                uart_rx,
   output logic                rx_irq_o
);
   localparam int CW = $clog2(TICKS_PER_BAUD);
   localparam int H  = TICKS_PER_BAUD / 2;
`ifdef WBS_UART_RX_MAJORITY_EN
   // Decision lands one edge after the centre so p+1 is available to the vote.
   localparam int START_LAST = H;
`else
   localparam int START_LAST = H - 1;
`endif
   localparam logic [CW-1:0] START_LAST_C = CW'(START_LAST);
   localparam logic [CW-1:0] BAUD_LAST_C  = CW'(TICKS_PER_BAUD - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   logic [1:0] sync_reg;
   logic       rx_s;
   logic       sample_bit;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) sync_reg <= 2'b11;
      else            sync_reg <= {sync_reg[0], uart_rx};
   end
   assign rx_s = sync_reg[1];

`ifdef WBS_UART_RX_MAJORITY_EN
   logic [1:0] hist_reg;
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) hist_reg <= 2'b11;
      else            hist_reg <= {hist_reg[0], rx_s};
   end
   assign sample_bit = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
   assign sample_bit = rx_s;
`endif

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          load, ferr_set;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   // cnt_reg holds (edges since last reference) - 1, so T-1 fits in CW bits.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      load       = 1'b0;
      ferr_set   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt_reg == START_LAST_C) begin
               cnt_next = '0;
               if (sample_bit) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  bit_next   = 3'd0;
               end
            end
         end
         DATA: begin
            if (cnt_reg == BAUD_LAST_C) begin
               cnt_next   = '0;
               shift_next = {sample_bit, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt_reg == BAUD_LAST_C) begin
               cnt_next = '0;
               if (sample_bit) begin
                  load       = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_set   = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (rx_s) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   logic [7:0] rx_data_reg;
   logic       valid_reg, overrun_reg, frame_err_reg;
   logic       ack_reg;
   logic [7:0] dat_reg;
   logic       read_fire, pop;
   logic [7:0] status;

   assign read_fire = wbs.wb_stb_i && !ack_reg;
   assign pop       = read_fire && !wbs.wb_adr_i;
   assign status    = {5'b0, overrun_reg, frame_err_reg, valid_reg};

   // A load on the pop edge wins: the reader gets the old byte, the new one stays valid.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rx_data_reg   <= '0;
         valid_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         ack_reg       <= 1'b0;
         dat_reg       <= '0;
      end else begin
         ack_reg <= read_fire;
         if (read_fire) dat_reg <= wbs.wb_adr_i ? status : rx_data_reg;
         if (load) begin
            rx_data_reg   <= shift_reg;
            valid_reg     <= 1'b1;
            overrun_reg   <= pop ? 1'b0 : (overrun_reg | valid_reg);
            frame_err_reg <= 1'b0;
         end else begin
            if (pop) begin
               valid_reg   <= 1'b0;
               overrun_reg <= 1'b0;
            end
            if (ferr_set) frame_err_reg <= 1'b1;
         end
      end
   end

   assign wbs.wb_ack_o = ack_reg;
   assign wbs.wb_dat_o = dat_reg;
   assign rx_irq_o     = valid_reg;
endmodule

// File: tb/tb_wbs_uart_rx.sv
// Randomized self-checking bench for wbs_uart_rx against a frame-level status model.
module tb_wbs_uart_rx;
   localparam int T = 16;
   localparam int H = T / 2;
`ifdef WBS_UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic irq;
   int   cyc = 0;
   int   rise_cyc = -1;
   logic irq_q = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   wbs_uart_rx_if wbs ();

   wbs_uart_rx #(.TICKS_PER_BAUD(T)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .wbs      (wbs),
      .uart_rx  (uart_rx),
      .rx_irq_o (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (irq && !irq_q) rise_cyc = cyc;
      irq_q = irq;
   end

   // reference: what software should observe after each complete frame / pop
   logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
   logic [7:0] m_data = 8'h00;

   function automatic int m_status();
      return int'({m_ovr, m_ferr, m_valid});
   endfunction

   task automatic model_frame(input logic [7:0] b, input logic good);
      if (good) begin
         m_ovr   = m_valid;
         m_valid = 1'b1;
         m_data  = b;
         m_ferr  = 1'b0;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   task automatic model_pop();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
   endtask

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // All tasks start and end #1 after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the line at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      $display("tx byte=%02h stop=%0d at cyc=%0d", b, stop_bit, cyc);
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         idle(T);
      end
   endtask

   task automatic wb_read(input logic adr, output logic [7:0] data);
      bit got_ack;
      got_ack = 1'b0;
      wbs.wb_stb_i = 1'b1;
      wbs.wb_adr_i = adr;
      for (int i = 0; i < 3 && !got_ack; i++) begin
         @(negedge clk);
         if (wbs.wb_ack_o) got_ack = 1'b1;
      end
      if (!got_ack) check_val("ack_timeout", 0, 1);
      data = wbs.wb_dat_o;
      $display("rd adr=%0d data=%02h cyc=%0d", adr, data, cyc);
      @(posedge clk); #1;
      wbs.wb_stb_i = 1'b0;
      @(negedge clk);
      check_val("ack_single", int'(wbs.wb_ack_o), 0);
      @(posedge clk); #1;
   endtask

   task automatic read_status(input string tag);
      logic [7:0] d;
      wb_read(1'b1, d);
      check_val(tag, int'(d), m_status());
   endtask

   task automatic read_data(input string tag);
      logic [7:0] d;
      wb_read(1'b0, d);
      check_val(tag, int'(d), int'(m_data));
      model_pop();
   endtask

   initial begin
      int          e, l;
      logic [7:0]  b, d;
      logic        good;
      wbs.wb_stb_i = 1'b0;
      wbs.wb_adr_i = 1'b0;

      // reset state
      idle(3);
      check_val("rst_ack", int'(wbs.wb_ack_o), 0);
      check_val("rst_dat", int'(wbs.wb_dat_o), 0);
      check_val("rst_irq", int'(irq), 0);
      rst_n = 1'b1;
      idle(3);
      read_status("rst_status");

      // single byte with latency
      rise_cyc = -1;
      e = cyc;
      send_frame(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1);
      check_val("irq_latency", rise_cyc, e + 2 + H + 9 * T + 1 + MAJ);
      read_status("single_status");
      read_data("single_data");
      read_status("single_status_after");

      // glitch reject
      uart_rx = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      idle(2 * T);
      check_val("glitch_irq", int'(irq), 0);
      read_status("glitch_status");

      // overrun
      send_frame(8'h11, 1'b1); model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1); model_frame(8'h22, 1'b1);
      read_status("ovr_status");
      read_data("ovr_data");
      read_status("ovr_status_after");

      // framing error followed by a long break
      send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
      idle(20 * T);
      uart_rx = 1'b1;
      idle(T);
      read_status("break_status");
      check_val("break_irq", int'(irq), 0);
      send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1'b1);
      read_status("ferr_clear_status");
      read_data("ferr_clear_data");

      // pop/load collision: DATA ack edge == load edge of second byte
      send_frame(8'h96, 1'b1); model_frame(8'h96, 1'b1);
      e = cyc;
      l = e + 3 + H + 9 * T + MAJ;
      fork
         send_frame(8'h4B, 1'b1);
         begin
            while (cyc < l - 1) idle(1);
            read_data("coll_old_data");
         end
      join
      model_frame(8'h4B, 1'b1);
      read_status("coll_status");
      read_data("coll_new_data");

      // async reset mid-frame (bit 4), with a byte pending and dat_o nonzero
      send_frame(8'h81, 1'b1); model_frame(8'h81, 1'b1);
      read_status("prerst_status");
      fork
         send_frame(8'hFF, 1'b1);
         begin
            idle(5 * T + H);
            rst_n = 1'b0;
            #2;
            check_val("midrst_ack", int'(wbs.wb_ack_o), 0);
            check_val("midrst_dat", int'(wbs.wb_dat_o), 0);
            check_val("midrst_irq", int'(irq), 0);
         end
      join
      model_reset();
      idle(2);
      rst_n = 1'b1;
      idle(3);
      read_status("postrst_status");
      send_frame(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
      read_status("postrst_rx_status");
      read_data("postrst_rx_data");

      // randomized traffic
      for (int i = 0; i < 12; i++) begin
         b    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 5) != 0);
         send_frame(b, good);
         model_frame(b, good);
         if (!good) begin
            uart_rx = 1'b1;
            idle(T);
         end
         case ($urandom_range(0, 2))
            0: idle($urandom_range(0, T));
            1: read_status("rnd_status");
            default: begin
               read_status("rnd_status");
               read_data("rnd_data");
            end
         endcase
      end
      read_status("final_status");
      wb_read(1'b0, d);
      check_val("final_data", int'(d), int'(m_data));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
